// File: rtl/emu_transactor.sv
// emu_transactor: host byte-link transactor for a DUT inside the emulation FPGA.
// The host loads stimulus bytes, steps the DUT through dut_ce for n cycles,
// then reads back the captured DUT outputs and a 16-bit enabled-cycle counter.
module emu_transactor #(
  parameter int STIM_BYTES = 2,
  parameter int OUT_BYTES  = 3,
  parameter int AW         = 4,
  parameter int HB_BIT     = 3
) (
  input  logic                    clk_emu,
  input  logic                    nRST_emu,
  input  logic                    cmd_vld,
  input  logic [1:0]              cmd_emu,
  input  logic [AW-1:0]           Addr_emu,
  input  logic [7:0]              Din_emu,
  output logic [7:0]              Dout_emu,
  output logic                    busy_emu,
  output logic [8*STIM_BYTES-1:0] dut_in,
  input  logic [8*OUT_BYTES-1:0]  dut_out,
  output logic                    dut_ce,
  output logic                    clk_LED
);

  localparam logic [1:0] CMD_WRITE = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_LOAD  = 2'b10;
  localparam logic [1:0] CMD_RUN   = 2'b11;

  // The counter bytes sit directly above the capture buffer in the read map.
  localparam logic [AW-1:0] CNT_LO_ADDR = AW'(OUT_BYTES);
  localparam logic [AW-1:0] CNT_HI_ADDR = AW'(OUT_BYTES + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    CAPT
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  run_cnt;
  logic [7:0]  run_cnt_nxt;
  logic        dut_ce_nxt;
  logic        busy_nxt;
  logic        capture;
  logic        cmd_ok;
  logic [7:0]  stim_buf [STIM_BYTES];
  logic [7:0]  cap_buf  [OUT_BYTES];
  logic [15:0] cyc_cnt;
  logic [7:0]  rd_byte;

  assign cmd_ok  = cmd_vld && (state == IDLE);
  assign clk_LED = cyc_cnt[HB_BIT];

  // Next-state logic: RUN loads n-1 and counts down to zero; CAPT is the settle/capture cycle.
  always_comb begin
    state_nxt   = state;
    run_cnt_nxt = run_cnt;
    dut_ce_nxt  = dut_ce;
    busy_nxt    = busy_emu;
    capture     = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_ok && (cmd_emu == CMD_RUN)) begin
          state_nxt   = RUN;
          dut_ce_nxt  = 1'b1;
          busy_nxt    = 1'b1;
          run_cnt_nxt = Din_emu - 8'd1;
        end
      end
      RUN: begin
        if (run_cnt == 8'd0) begin
          state_nxt  = CAPT;
          dut_ce_nxt = 1'b0;
        end else begin
          run_cnt_nxt = run_cnt - 8'd1;
        end
      end
      CAPT: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
        capture   = 1'b1;
      end
      default: begin
        state_nxt  = IDLE;
        dut_ce_nxt = 1'b0;
        busy_nxt   = 1'b0;
      end
    endcase
  end

  // FSM and run-control registers; reset aborts any RUN without capturing.
  always_ff @(posedge clk_emu or negedge nRST_emu) begin
    if (!nRST_emu) begin
      state    <= IDLE;
      run_cnt  <= 8'd0;
      dut_ce   <= 1'b0;
      busy_emu <= 1'b0;
    end else begin
      state    <= state_nxt;
      run_cnt  <= run_cnt_nxt;
      dut_ce   <= dut_ce_nxt;
      busy_emu <= busy_nxt;
    end
  end

  // Stimulus buffer writes and the one-edge LOAD into dut_in.
  always_ff @(posedge clk_emu or negedge nRST_emu) begin
    if (!nRST_emu) begin
      for (int i = 0; i < STIM_BYTES; i++) stim_buf[i] <= 8'd0;
      dut_in <= '0;
    end else if (cmd_ok) begin
      if (cmd_emu == CMD_WRITE) begin
        for (int i = 0; i < STIM_BYTES; i++) begin
          if (Addr_emu == AW'(i)) stim_buf[i] <= Din_emu;
        end
      end
      if (cmd_emu == CMD_LOAD) begin
        for (int i = 0; i < STIM_BYTES; i++) dut_in[8*i +: 8] <= stim_buf[i];
      end
    end
  end

  // Capture all DUT output bytes once the DUT has settled after the last enabled edge.
  always_ff @(posedge clk_emu or negedge nRST_emu) begin
    if (!nRST_emu) begin
      for (int i = 0; i < OUT_BYTES; i++) cap_buf[i] <= 8'd0;
    end else if (capture) begin
      for (int i = 0; i < OUT_BYTES; i++) cap_buf[i] <= dut_out[8*i +: 8];
    end
  end

  // Free-running count of enabled DUT cycles, wrapping at 16 bits.
  always_ff @(posedge clk_emu or negedge nRST_emu) begin
    if (!nRST_emu) begin
      cyc_cnt <= 16'd0;
    end else if (dut_ce) begin
      cyc_cnt <= cyc_cnt + 16'd1;
    end
  end

  // Read map: capture bytes, then counter low/high, zero elsewhere.
  always_comb begin
    rd_byte = 8'd0;
    for (int i = 0; i < OUT_BYTES; i++) begin
      if (Addr_emu == AW'(i)) rd_byte = cap_buf[i];
    end
    if (Addr_emu == CNT_LO_ADDR) rd_byte = cyc_cnt[7:0];
    if (Addr_emu == CNT_HI_ADDR) rd_byte = cyc_cnt[15:8];
  end

  // Dout_emu only changes on an accepted READ.
  always_ff @(posedge clk_emu or negedge nRST_emu) begin
    if (!nRST_emu) begin
      Dout_emu <= 8'd0;
    end else if (cmd_ok && (cmd_emu == CMD_READ)) begin
      Dout_emu <= rd_byte;
    end
  end

endmodule

// File: tb/tb_emu_transactor.sv
// tb_emu_transactor: randomized bench for emu_transactor with a counter DUT
// stand-in and a byte-level reference model of the host-visible behaviour.
module tb_emu_transactor;

  localparam int STIM_BYTES = 2;
  localparam int OUT_BYTES  = 3;
  localparam int AW         = 4;
  localparam int HB_BIT     = 3;

  localparam logic [1:0] C_WRITE = 2'b00;
  localparam logic [1:0] C_READ  = 2'b01;
  localparam logic [1:0] C_LOAD  = 2'b10;
  localparam logic [1:0] C_RUN   = 2'b11;

  logic                    clk_emu;
  logic                    nRST_emu;
  logic                    cmd_vld;
  logic [1:0]              cmd_emu;
  logic [AW-1:0]           Addr_emu;
  logic [7:0]              Din_emu;
  logic [7:0]              Dout_emu;
  logic                    busy_emu;
  logic [8*STIM_BYTES-1:0] dut_in;
  logic [8*OUT_BYTES-1:0]  dut_out;
  logic                    dut_ce;
  logic                    clk_LED;

  int errors;
  int checks;

  // Reference model state
  logic [7:0]  m_stim [STIM_BYTES];
  logic [15:0] m_dut_in;
  logic [7:0]  m_cap  [OUT_BYTES];
  int          m_cyc;

  // Counter DUT stand-in: counts enabled edges and records xor of stimulus bytes it sampled
  logic [15:0] tb_dut_cnt;
  logic [7:0]  tb_dut_smp;

  emu_transactor #(
    .STIM_BYTES(STIM_BYTES),
    .OUT_BYTES (OUT_BYTES),
    .AW        (AW),
    .HB_BIT    (HB_BIT)
  ) u_dut (
    .clk_emu (clk_emu),
    .nRST_emu(nRST_emu),
    .cmd_vld (cmd_vld),
    .cmd_emu (cmd_emu),
    .Addr_emu(Addr_emu),
    .Din_emu (Din_emu),
    .Dout_emu(Dout_emu),
    .busy_emu(busy_emu),
    .dut_in  (dut_in),
    .dut_out (dut_out),
    .dut_ce  (dut_ce),
    .clk_LED (clk_LED)
  );

  initial clk_emu = 1'b0;
  always #5 clk_emu = ~clk_emu;

  always @(posedge clk_emu or negedge nRST_emu) begin
    if (!nRST_emu) begin
      tb_dut_cnt <= 16'd0;
      tb_dut_smp <= 8'd0;
    end else if (dut_ce) begin
      tb_dut_cnt <= tb_dut_cnt + 16'd1;
      tb_dut_smp <= dut_in[7:0] ^ dut_in[15:8];
    end
  end
  assign dut_out = {tb_dut_smp, tb_dut_cnt};

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] exp_read(input int a);
    if (a < OUT_BYTES) return m_cap[a];
    if (a == OUT_BYTES) return 8'(m_cyc % 256);
    if (a == OUT_BYTES + 1) return 8'((m_cyc / 256) % 256);
    return 8'h00;
  endfunction

  function automatic int exp_toggles(input int start, input int n);
    int t = 0;
    for (int i = start + 1; i <= start + n; i++) if ((i % (1 << HB_BIT)) == 0) t++;
    return t;
  endfunction

  function automatic int run_len(input logic [7:0] d);
    return (d == 8'd0) ? 256 : int'(d);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < STIM_BYTES; i++) m_stim[i] = 8'd0;
    for (int i = 0; i < OUT_BYTES; i++) m_cap[i] = 8'd0;
    m_dut_in = 16'd0;
    m_cyc    = 0;
  endtask

  task automatic model_write(input int a, input logic [7:0] d);
    if (a < STIM_BYTES) m_stim[a] = d;
  endtask

  task automatic model_load();
    for (int i = 0; i < STIM_BYTES; i++) m_dut_in[8*i +: 8] = m_stim[i];
  endtask

  task automatic model_run(input int n);
    m_cyc    = (m_cyc + n) % 65536;
    m_cap[0] = 8'(m_cyc % 256);
    m_cap[1] = 8'(m_cyc / 256);
    m_cap[2] = m_dut_in[7:0] ^ m_dut_in[15:8];
  endtask

  // All drive tasks start and end at a falling edge of clk_emu.
  task automatic do_cmd(input logic [1:0] c, input int a, input logic [7:0] d);
    cmd_vld  = 1'b1;
    cmd_emu  = c;
    Addr_emu = AW'(a);
    Din_emu  = d;
    @(negedge clk_emu);
    cmd_vld  = 1'b0;
    cmd_emu  = 2'b00;
  endtask

  // Issue RUN and watch until busy drops; optionally fire WRITE and LOAD while busy.
  task automatic do_run(input logic [7:0] d, input bit inject, input logic [7:0] inj_data,
                        output int ce_cyc, output int busy_cyc, output int toggles, output bit timeout);
    logic led_prev;
    bit   done;
    ce_cyc   = 0;
    busy_cyc = 0;
    toggles  = 0;
    done     = 1'b0;
    led_prev = clk_LED;
    do_cmd(C_RUN, $urandom_range(0, 15), d);
    for (int k = 0; k < 400; k++) begin
      if (clk_LED !== led_prev) toggles++;
      led_prev = clk_LED;
      if (dut_ce === 1'b1) ce_cyc++;
      if (busy_emu !== 1'b1) begin
        done = 1'b1;
        break;
      end
      busy_cyc++;
      cmd_vld = 1'b0;
      if (inject && k == 1) begin
        cmd_vld = 1'b1; cmd_emu = C_WRITE; Addr_emu = '0; Din_emu = inj_data;
      end else if (inject && k == 2) begin
        cmd_vld = 1'b1; cmd_emu = C_LOAD;
      end
      @(negedge clk_emu);
    end
    cmd_vld = 1'b0;
    timeout = !done;
  endtask

  task automatic test_reset();
    nRST_emu = 1'b0;
    cmd_vld  = 1'b0;
    cmd_emu  = 2'b00;
    Addr_emu = '0;
    Din_emu  = 8'd0;
    model_reset();
    repeat (3) @(negedge clk_emu);
    nRST_emu = 1'b1;
    @(negedge clk_emu);
    checks++;
    if ({busy_emu, dut_ce, clk_LED} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_flags: got busy/ce/led=%b expected 000", {busy_emu, dut_ce, clk_LED});
    end
    checks++;
    if (dut_in !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_dut_in: got %h expected 0000", dut_in);
    end
    for (int a = 0; a <= OUT_BYTES + 1; a++) begin
      do_cmd(C_READ, a, 8'h00);
      checks++;
      if (Dout_emu !== 8'h00) begin
        errors++;
        $display("[TB] FAIL reset_read[%0d]: got %h expected 00", a, Dout_emu);
      end
    end
  endtask

  task automatic test_write_load();
    do_cmd(C_WRITE, 0, 8'h3C);          model_write(0, 8'h3C);
    do_cmd(C_WRITE, 1, 8'h81);          model_write(1, 8'h81);
    do_cmd(C_WRITE, STIM_BYTES, 8'h5A); model_write(STIM_BYTES, 8'h5A);
    checks++;
    if (dut_in !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL dut_in_before_load: got %h expected 0000", dut_in);
    end
    do_cmd(C_LOAD, 0, 8'h00);
    model_load();
    checks++;
    if (dut_in !== 16'h813C) begin
      errors++;
      $display("[TB] FAIL dut_in_after_load: got %h expected 813c", dut_in);
    end
  endtask

  task automatic test_run_5();
    int ce_c, busy_c, tog;
    bit to;
    do_run(8'd5, 1'b0, 8'h00, ce_c, busy_c, tog, to);
    model_run(5);
    checks++;
    if (to || ce_c != 5 || busy_c != 6) begin
      errors++;
      $display("[TB] FAIL run5_timing: got ce=%0d busy=%0d timeout=%0d expected ce=5 busy=6", ce_c, busy_c, to);
    end
    do_cmd(C_READ, OUT_BYTES, 8'h00);
    checks++;
    if (Dout_emu !== 8'h05) begin
      errors++;
      $display("[TB] FAIL run5_cyc_lo: got %h expected 05", Dout_emu);
    end
    for (int a = 0; a < OUT_BYTES; a++) begin
      do_cmd(C_READ, a, 8'h00);
      checks++;
      if (Dout_emu !== exp_read(a)) begin
        errors++;
        $display("[TB] FAIL run5_cap[%0d]: got %h expected %h", a, Dout_emu, exp_read(a));
      end
    end
  endtask

  task automatic test_run_256();
    int ce_c, busy_c, tog, exp_tog;
    bit to;
    exp_tog = exp_toggles(m_cyc, 256);
    do_run(8'd0, 1'b0, 8'h00, ce_c, busy_c, tog, to);
    model_run(256);
    checks++;
    if (to || ce_c != 256 || busy_c != 257) begin
      errors++;
      $display("[TB] FAIL run256_timing: got ce=%0d busy=%0d timeout=%0d expected ce=256 busy=257", ce_c, busy_c, to);
    end
    checks++;
    if (tog != exp_tog) begin
      errors++;
      $display("[TB] FAIL run256_led_toggles: got %0d expected %0d", tog, exp_tog);
    end
    do_cmd(C_READ, OUT_BYTES + 1, 8'h00);
    checks++;
    if (Dout_emu !== 8'h01) begin
      errors++;
      $display("[TB] FAIL run256_cyc_hi: got %h expected 01", Dout_emu);
    end
  endtask

  task automatic test_busy_ignore();
    int ce_c, busy_c, tog, n;
    bit to;
    logic [7:0] d;
    d = 8'($urandom_range(4, 40));
    n = run_len(d);
    do_run(d, 1'b1, ~m_stim[0], ce_c, busy_c, tog, to);
    model_run(n);
    checks++;
    if (to || ce_c != n || busy_c != n + 1) begin
      errors++;
      $display("[TB] FAIL busy_run_timing: got ce=%0d busy=%0d expected ce=%0d busy=%0d", ce_c, busy_c, n, n + 1);
    end
    checks++;
    if (dut_in !== m_dut_in) begin
      errors++;
      $display("[TB] FAIL busy_load_ignored: got %h expected %h", dut_in, m_dut_in);
    end
    do_cmd(C_LOAD, 0, 8'h00);
    model_load();
    checks++;
    if (dut_in !== m_dut_in) begin
      errors++;
      $display("[TB] FAIL busy_write_ignored: got %h expected %h", dut_in, m_dut_in);
    end
    do_cmd(C_READ, 2, 8'h00);
    checks++;
    if (Dout_emu !== exp_read(2)) begin
      errors++;
      $display("[TB] FAIL busy_cap_sample: got %h expected %h", Dout_emu, exp_read(2));
    end
  endtask

  task automatic test_back_to_back();
    int ce_c, busy_c, tog, n;
    bit to;
    logic [7:0] d, b0, b1;
    for (int it = 0; it < 3; it++) begin
      b0 = 8'($urandom);
      b1 = 8'($urandom);
      d  = 8'($urandom_range(1, 20));
      n  = run_len(d);
      do_cmd(C_WRITE, 0, b0); model_write(0, b0);
      do_cmd(C_WRITE, 1, b1); model_write(1, b1);
      do_cmd(C_LOAD, 0, 8'h00); model_load();
      do_run(d, 1'b0, 8'h00, ce_c, busy_c, tog, to);
      model_run(n);
      checks++;
      if (to || ce_c != n || busy_c != n + 1) begin
        errors++;
        $display("[TB] FAIL b2b_timing: got ce=%0d busy=%0d expected ce=%0d busy=%0d", ce_c, busy_c, n, n + 1);
      end
      do_cmd(C_READ, 2, 8'h00);
      checks++;
      if (Dout_emu !== exp_read(2)) begin
        errors++;
        $display("[TB] FAIL b2b_first_edge_stim: got %h expected %h", Dout_emu, exp_read(2));
      end
      do_cmd(C_READ, OUT_BYTES, 8'h00);
      checks++;
      if (Dout_emu !== exp_read(OUT_BYTES)) begin
        errors++;
        $display("[TB] FAIL b2b_cyc_lo: got %h expected %h", Dout_emu, exp_read(OUT_BYTES));
      end
    end
  endtask

  task automatic test_random_ops();
    int op, a, ce_c, busy_c, tog, n;
    bit to;
    logic [7:0] d;
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 3);
      a  = $urandom_range(0, (1 << AW) - 1);
      d  = 8'($urandom);
      case (op)
        0: begin do_cmd(C_WRITE, a, d); model_write(a, d); end
        1: begin
          do_cmd(C_READ, a, d);
          checks++;
          if (Dout_emu !== exp_read(a)) begin
            errors++;
            $display("[TB] FAIL rand_read[%0d]: got %h expected %h", a, Dout_emu, exp_read(a));
          end
        end
        2: begin do_cmd(C_LOAD, a, d); model_load(); end
        default: begin
          d = 8'($urandom_range(1, 12));
          n = run_len(d);
          do_run(d, 1'b0, 8'h00, ce_c, busy_c, tog, to);
          model_run(n);
          checks++;
          if (to || ce_c != n || busy_c != n + 1) begin
            errors++;
            $display("[TB] FAIL rand_run_timing: got ce=%0d busy=%0d expected ce=%0d busy=%0d", ce_c, busy_c, n, n + 1);
          end
        end
      endcase
      checks++;
      if (dut_in !== m_dut_in) begin
        errors++;
        $display("[TB] FAIL rand_dut_in: got %h expected %h", dut_in, m_dut_in);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int ce_c, busy_c, tog, n;
    bit to;
    logic [7:0] d;
    d = 8'($urandom_range(8, 40));
    n = run_len(d);
    do_cmd(C_RUN, 0, d);
    // Step to the cycle where the internal count reads 3
    for (int k = 0; k < n - 4; k++) @(negedge clk_emu);
    #2 nRST_emu = 1'b0;
    #1;
    checks++;
    if ({busy_emu, dut_ce} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL abort_async: got busy/ce=%b expected 00", {busy_emu, dut_ce});
    end
    model_reset();
    @(negedge clk_emu);
    nRST_emu = 1'b1;
    @(negedge clk_emu);
    checks++;
    if ({busy_emu, dut_ce, dut_in} !== 18'd0) begin
      errors++;
      $display("[TB] FAIL abort_state: got busy=%b ce=%b dut_in=%h expected all zero", busy_emu, dut_ce, dut_in);
    end
    for (int a = 0; a <= OUT_BYTES + 1; a++) begin
      do_cmd(C_READ, a, 8'h00);
      checks++;
      if (Dout_emu !== 8'h00) begin
        errors++;
        $display("[TB] FAIL abort_read[%0d]: got %h expected 00", a, Dout_emu);
      end
    end
    do_run(8'd2, 1'b0, 8'h00, ce_c, busy_c, tog, to);
    model_run(2);
    checks++;
    if (to || ce_c != 2 || busy_c != 3) begin
      errors++;
      $display("[TB] FAIL abort_idle_after: got ce=%0d busy=%0d expected ce=2 busy=3", ce_c, busy_c);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_write_load();
    test_run_5();
    test_run_256();
    test_busy_ignore();
    test_back_to_back();
    test_random_ops();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/emu_transactor.md
# emu_transactor

Parametrised co-emulation transactor that sits between the host byte link and a DUT inside the emulation FPGA. It generalises the fixed 8-byte stimulus/capture wrapper to arbitrary stimulus and capture widths. It adds two features the fixed wrapper lacks:
- the DUT advances only through a clock enable for a host-specified number of cycles, with automatic output capture afterwards;
- a 16-bit DUT cycle counter that the host can read back.

## Interface
Parameters:
- STIM_BYTES, default 2: stimulus bytes driven to the DUT (1..2^AW).
- OUT_BYTES, default 3: captured DUT output bytes (OUT_BYTES+2 <= 2^AW).
- AW, default 4: width of Addr_emu.
- HB_BIT, default 3: bit of the cycle counter that drives clk_LED.

Ports:
- clk_emu, in, 1: single clock for the transactor and the DUT (the DUT uses dut_ce).
- nRST_emu, in, 1: asynchronous, active-low reset.
- cmd_vld, in, 1: command strobe, sampled on the rising edge of clk_emu.
- cmd_emu, in, 2: 00 WRITE, 01 READ, 10 LOAD, 11 RUN.
- Addr_emu, in, AW: byte address for WRITE and READ.
- Din_emu, in, 8: write data for WRITE; cycle count for RUN.
- Dout_emu, out, 8: registered read data.
- busy_emu, out, 1: high while a RUN is in progress.
- dut_in, out, 8*STIM_BYTES: registered stimulus applied to the DUT inputs.
- dut_out, in, 8*OUT_BYTES: DUT outputs.
- dut_ce, out, 1: DUT clock enable.
- clk_LED, out, 1: cyc_cnt[HB_BIT], emulation-activity heartbeat.

## Operation
- Storage:
  - stim_buf[0..STIM_BYTES-1] x 8 bits.
  - cap_buf[0..OUT_BYTES-1] x 8 bits.
  - cyc_cnt, 16 bits.
  - Byte i maps to bits [8i+7:8i] of dut_in and of dut_out.
- FSM states: IDLE, RUN, CAPT. Commands are accepted only in IDLE; cmd_vld in RUN or CAPT is ignored with no side effect.
- WRITE: stim_buf[Addr_emu] <= Din_emu. If Addr_emu >= STIM_BYTES the write is dropped.
- READ: Dout_emu <= the byte at Addr_emu:
  - Addr < OUT_BYTES: cap_buf[Addr].
  - Addr == OUT_BYTES: cyc_cnt[7:0].
  - Addr == OUT_BYTES+1: cyc_cnt[15:8].
  - Any other address: 0x00.
  - Dout_emu holds its value until the next READ.
- LOAD: dut_in <= concatenation of all stim_buf bytes, updated in one edge. Writes to stim_buf never reach dut_in without a LOAD.
- RUN, with n = Din_emu (0 means 256):
  - IDLE -> RUN: dut_ce <= 1, busy_emu <= 1, internal count <= n-1.
  - In RUN, each edge decrements the count. On the edge where the count is 0: dut_ce <= 0 and the FSM moves to CAPT.
  - CAPT -> IDLE: cap_buf <= dut_out (all bytes), busy_emu <= 0.
- cyc_cnt increments on every edge where dut_ce = 1. It wraps from 0xFFFF to 0x0000 and is cleared only by reset.
- Reset (asynchronous, nRST_emu low):
  - FSM returns to IDLE.
  - stim_buf, cap_buf, cyc_cnt, dut_in and Dout_emu all clear to 0.
  - dut_ce = 0 and busy_emu = 0 immediately, including when reset hits mid-RUN. No capture occurs for an aborted RUN.

## Timing
- All outputs are registered. Nothing is combinational from inputs to outputs.
- WRITE, LOAD and READ take effect on the edge that samples cmd_vld:
  - READ data is valid on Dout_emu in the following cycle.
  - dut_in changes in the cycle after LOAD.
- RUN sampled at edge E0:
  - dut_ce is high for exactly n cycles (after E0 through E(n-1)). The DUT advances n times.
  - cap_buf is written at edge E(n+1).
  - busy_emu is high for n+1 cycles and is low after E(n+1).
  - Total latency from the command edge to data available for READ is n+1 cycles.
- Back-to-back commands:
  - A command in the first cycle busy_emu is low is accepted.
  - LOAD and RUN in consecutive cycles: the DUT sees the new dut_in on its first enabled edge.
- The DUT samples dut_in and produces dut_out on clk_emu edges qualified by dut_ce. Outputs must be settled one cycle after the last enabled edge; the CAPT cycle guarantees this.

## Test plan
- Reset then READ at addresses 0..OUT_BYTES+1 -> Dout_emu = 0x00 for every address; busy_emu = 0, dut_ce = 0, clk_LED = 0.
- WRITE 0x3C to addr 0 and 0x81 to addr 1, WRITE to addr STIM_BYTES, then LOAD -> dut_in = 0x813C. The out-of-range write changes nothing. dut_in is unchanged before the LOAD.
- With a counter DUT, RUN with Din_emu = 5 -> dut_ce high exactly 5 cycles, busy_emu high 6 cycles, cap_buf reflects a count of 5. READ at OUT_BYTES -> 0x05.
- RUN with Din_emu = 0 -> 256 dut_ce cycles. cyc_cnt[15:8] = 0x01. clk_LED toggles every 8 enabled cycles.
- Issue WRITE and LOAD while busy_emu = 1 -> stim_buf and dut_in are unchanged. RUN completes normally.
- Assert nRST_emu low during a RUN at count 3 -> dut_ce and busy_emu drop asynchronously, cap_buf = 0, and the FSM is in IDLE after release.
